// File: rtl/top_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : top_pkg
//  Description : Shared constants for the coincidence counter display:
//                BCD-to-seven-segment table (active-low, {g,f,e,d,c,b,a}),
//                blank segment code and number of display digits.
//  Revision    : 1.0 - initial release
// ============================================================================
package top_pkg;

    localparam int c_NUM_DIGITS = 8;

    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    // Entry [n] holds the active-low pattern for decimal digit n.
    localparam logic [9:0][6:0] c_SEG_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Non-BCD nibbles decode to a dark digit rather than garbage.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = c_SEG_BLANK;
        if (nibble <= 4'd9) begin
            seg = c_SEG_TABLE[nibble];
        end
        return seg;
    endfunction

endpackage : top_pkg
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter4
//  Description : Four-digit packed BCD counter 0000..9999, wrapping to 0000.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset (clears to 0000)
//                inc    - increment by one on this clock edge
//                digits - packed BCD value, [15:12] thousands .. [3:0] units
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] digits
);

    logic [15:0] r_digits;
    logic [15:0] w_next;
    logic        w_carry;

    // Ripple a decimal carry from units upward; a digit at 9 rolls to 0 and
    // passes the carry on, so 9999 naturally becomes 0000.
    always_comb begin
        w_next  = r_digits;
        w_carry = inc;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_digits[i*4 +: 4] >= 4'd9) begin
                    w_next[i*4 +: 4] = 4'd0;
                end else begin
                    w_next[i*4 +: 4] = r_digits[i*4 +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 16'h0000;
        end else begin
            r_digits <= w_next;
        end
    end

    assign digits = r_digits;

endmodule : bcd_counter4
`default_nettype wire

// File: rtl/top_core.sv
`default_nettype none
// ============================================================================
//  Module      : top_core
//  Description : Input conditioning and event counting. Synchronizes the two
//                button channels and the mode switch, detects press and
//                coincidence rising edges and drives three BCD counters.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                i_buttons    - raw asynchronous buttons {B, A}
//                i_sw_mode    - raw asynchronous mode switch
//                o_count_a/b/c- packed BCD counts for A, B and coincidence
//                o_mode       - synchronized mode switch
//  Revision    : 1.0 - initial release
// ============================================================================
module top_core
    import top_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_buttons,
    input  logic        i_sw_mode,
    output logic [15:0] o_count_a,
    output logic [15:0] o_count_b,
    output logic [15:0] o_count_c,
    output logic        o_mode
);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             r_mode_sync;
    logic                   r_prev_a;
    logic                   r_prev_b;
    logic                   r_prev_ab;
    // Fills with ones after reset release; edges are ignored until the
    // synchronizer and the edge-detect registers both hold real input
    // values, so a button held across reset release never counts.
    logic [SYNC_STAGES:0]   r_arm;

    logic w_sync_a;
    logic w_sync_b;
    logic w_both;
    logic w_armed;
    logic w_inc_a;
    logic w_inc_b;
    logic w_inc_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a    <= '0;
            r_sync_b    <= '0;
            r_mode_sync <= 2'b00;
            r_prev_a    <= 1'b0;
            r_prev_b    <= 1'b0;
            r_prev_ab   <= 1'b0;
            r_arm       <= '0;
        end else begin
            r_sync_a    <= {r_sync_a[SYNC_STAGES-2:0], i_buttons[0]};
            r_sync_b    <= {r_sync_b[SYNC_STAGES-2:0], i_buttons[1]};
            r_mode_sync <= {r_mode_sync[0], i_sw_mode};
            r_prev_a    <= w_sync_a;
            r_prev_b    <= w_sync_b;
            r_prev_ab   <= w_both;
            r_arm       <= {r_arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sync_a = r_sync_a[SYNC_STAGES-1];
    assign w_sync_b = r_sync_b[SYNC_STAGES-1];
    assign w_both   = w_sync_a & w_sync_b;
    assign w_armed  = r_arm[SYNC_STAGES];

    // Coincidence is its own edge detector on A&B, so pressing one button
    // while the other is already held also counts as a coincidence.
    assign w_inc_a = w_armed & w_sync_a & ~r_prev_a;
    assign w_inc_b = w_armed & w_sync_b & ~r_prev_b;
    assign w_inc_c = w_armed & w_both   & ~r_prev_ab;

    bcd_counter4 counter_A (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_inc_a),
        .digits (o_count_a)
    );

    bcd_counter4 counter_B (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_inc_b),
        .digits (o_count_b)
    );

    bcd_counter4 counter_C (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_inc_c),
        .digits (o_count_c)
    );

    assign o_mode = r_mode_sync[1];

endmodule : top_core
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
//  Module      : top
//  Description : Two-channel press / coincidence counter with an 8-digit
//                multiplexed seven-segment display.
//  Ports       : clk      - system clock (100 MHz nominal)
//                rst_n    - asynchronous active-low reset
//                buttons  - raw inputs, bit0 = channel A, bit1 = channel B
//                sw_mode  - 0: digits 7..4 = B, 3..0 = A; 1: digits 3..0 = C
//                segments - active-low {g,f,e,d,c,b,a}, registered
//                anodes   - active-low digit enables, digit 0 rightmost
//  Revision    : 1.0 - initial release
// ============================================================================
module top
    import top_pkg::*;
#(
    parameter int REFRESH_BITS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] buttons,
    input  logic       sw_mode,
    output logic [6:0] segments,
    output logic [7:0] anodes
);

    logic [15:0]             w_count_a;
    logic [15:0]             w_count_b;
    logic [15:0]             w_count_c;
    logic                    w_mode;
    logic [REFRESH_BITS+2:0] r_scan;
    logic [2:0]              w_digit_sel;
    logic [3:0]              w_nib_pos;
    logic [3:0]              w_nibble;
    logic [c_NUM_DIGITS-1:0] w_anodes;
    logic [6:0]              w_segments;
    logic [c_NUM_DIGITS-1:0] r_anodes;
    logic [6:0]              r_segments;

    top_core #(
        .SYNC_STAGES (SYNC_STAGES)
    ) core_inst (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_buttons (buttons),
        .i_sw_mode (sw_mode),
        .o_count_a (w_count_a),
        .o_count_b (w_count_b),
        .o_count_c (w_count_c),
        .o_mode    (w_mode)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign w_digit_sel = r_scan[REFRESH_BITS+2 -: 3];
    assign w_nib_pos   = {w_digit_sel[1:0], 2'b00};

    always_comb begin
        w_nibble   = 4'd0;
        w_anodes   = '1;
        w_segments = c_SEG_BLANK;
        if (!w_mode) begin
            w_nibble = w_digit_sel[2] ? w_count_b[w_nib_pos +: 4]
                                      : w_count_a[w_nib_pos +: 4];
            w_anodes[w_digit_sel] = 1'b0;
            w_segments            = seg_encode(w_nibble);
        end else if (!w_digit_sel[2]) begin
            w_nibble              = w_count_c[w_nib_pos +: 4];
            w_anodes[w_digit_sel] = 1'b0;
            w_segments            = seg_encode(w_nibble);
        end
    end

    // Both outputs come from the same register stage so a digit's anode and
    // its segment pattern always switch on the same edge (no ghosting).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anodes   <= '1;
            r_segments <= c_SEG_BLANK;
        end else begin
            r_anodes   <= w_anodes;
            r_segments <= w_segments;
        end
    end

    assign anodes   = r_anodes;
    assign segments = r_segments;

endmodule : top
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_top
//  Description : Directed self-checking bench for top (press counting,
//                coincidence, BCD wrap, display scan, asynchronous reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

    localparam int RB        = 2;
    localparam int SCAN_LEN  = 8 * (1 << RB);

    logic       clk;
    logic       rst_n;
    logic [1:0] buttons;
    logic       sw_mode;
    logic [6:0] segments;
    logic [7:0] anodes;

    int errors;
    int checks;

    top #(
        .REFRESH_BITS (RB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .buttons  (buttons),
        .sw_mode  (sw_mode),
        .segments (segments),
        .anodes   (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: exp_seg = 7'h40;
            4'd1: exp_seg = 7'h79;
            4'd2: exp_seg = 7'h24;
            4'd3: exp_seg = 7'h30;
            4'd4: exp_seg = 7'h19;
            4'd5: exp_seg = 7'h12;
            4'd6: exp_seg = 7'h02;
            4'd7: exp_seg = 7'h78;
            4'd8: exp_seg = 7'h00;
            4'd9: exp_seg = 7'h10;
            default: exp_seg = 7'h7F;
        endcase
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        buttons = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] mask, input int hi, input int lo);
        buttons = mask;
        repeat (hi) @(negedge clk);
        buttons = 2'b00;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input logic [15:0] ea,
                                input logic [15:0] eb, input logic [15:0] ec);
        logic [15:0] a, b, c;
        a = dut.core_inst.counter_A.digits;
        b = dut.core_inst.counter_B.digits;
        c = dut.core_inst.counter_C.digits;
        checks++;
        if (a !== ea || b !== eb || c !== ec) begin
            errors++;
            $display("FAIL %s: got A=%h B=%h C=%h, expected A=%h B=%h C=%h",
                     tag, a, b, c, ea, eb, ec);
        end
    endtask

    // Watch one full scan and verify every lit digit against lo/hi values.
    task automatic check_display(input string tag, input logic mode,
                                 input logic [15:0] lo, input logic [15:0] hi);
        logic [7:0] seen;
        logic [7:0] an;
        logic [6:0] sg;
        logic [6:0] want;
        logic [3:0] nib;
        int         idx;
        seen = 8'h00;
        for (int n = 0; n < SCAN_LEN; n++) begin
            @(negedge clk);
            an  = anodes;
            sg  = segments;
            idx = -1;
            for (int k = 0; k < 8; k++) begin
                if (an == ~(8'h01 << k)) idx = k;
            end
            checks++;
            if (idx < 0) begin
                if (!(mode && an == 8'hFF && sg == 7'h7F)) begin
                    errors++;
                    $display("FAIL %s scan: anodes=%h segments=%h not a valid digit select",
                             tag, an, sg);
                end
            end else if (mode && idx >= 4) begin
                errors++;
                $display("FAIL %s blank: digit %0d lit in mode 1 (anodes=%h)", tag, idx, an);
            end else begin
                seen[idx] = 1'b1;
                nib  = (idx < 4) ? lo[idx*4 +: 4] : hi[(idx-4)*4 +: 4];
                want = exp_seg(nib);
                if (sg !== want) begin
                    errors++;
                    $display("FAIL %s digit%0d: segments=%h expected %h", tag, idx, sg, want);
                end
            end
        end
        checks++;
        if (seen !== (mode ? 8'h0F : 8'hFF)) begin
            errors++;
            $display("FAIL %s coverage: digits seen=%h expected %h",
                     tag, seen, mode ? 8'h0F : 8'hFF);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        buttons = 2'b00;
        sw_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (anodes !== 8'hFF || segments !== 7'h7F) begin
            errors++;
            $display("FAIL reset_outputs: anodes=%h segments=%h expected FF 7F", anodes, segments);
        end
        check_counts("reset_counts", 16'h0000, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_display("reset_zeros", 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_isolated_a();
        do_reset();
        // First press also checks the SYNC_STAGES+1 latency.
        buttons = 2'b01;
        repeat (2) @(negedge clk);
        check_counts("latency_before", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check_counts("latency_after", 16'h0001, 16'h0000, 16'h0000);
        repeat (12) @(negedge clk);
        buttons = 2'b00;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) press(2'b01, 15, 10);
        check_counts("isolated_a", 16'h0005, 16'h0000, 16'h0000);
        check_display("isolated_disp", 1'b0, 16'h0005, 16'h0000);
    endtask

    task automatic test_mixed();
        do_reset();
        for (int i = 0; i < 25; i++) press(2'b11, 8, 8);
        check_counts("simultaneous", 16'h0025, 16'h0025, 16'h0025);
        for (int i = 0; i < 25; i++) press((i % 2 == 0) ? 2'b01 : 2'b10, 8, 8);
        check_counts("mixed", 16'h0038, 16'h0037, 16'h0025);
        check_display("mixed_mode0", 1'b0, 16'h0038, 16'h0037);
    endtask

    task automatic test_mode1_scan();
        sw_mode = 1'b1;
        repeat (4) @(negedge clk);
        check_display("mode1", 1'b1, 16'h0025, 16'h0000);
        check_counts("mode1_counts", 16'h0038, 16'h0037, 16'h0025);
        sw_mode = 1'b0;
        repeat (4) @(negedge clk);
        check_display("mode0_back", 1'b0, 16'h0038, 16'h0037);
    endtask

    task automatic test_hold_overlap();
        do_reset();
        buttons = 2'b10;
        repeat (10) @(negedge clk);
        buttons = 2'b11;
        repeat (10) @(negedge clk);
        buttons = 2'b10;
        repeat (10) @(negedge clk);
        check_counts("overlap", 16'h0001, 16'h0001, 16'h0001);
        buttons = 2'b00;
        repeat (10) @(negedge clk);
        press(2'b01, 10, 10);
        check_counts("a_alone", 16'h0002, 16'h0001, 16'h0001);
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(2'b01, 10, 10);
        press(2'b01, 10, 10);
        check_counts("pre_reset", 16'h0002, 16'h0000, 16'h0000);
        buttons = 2'b01;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (anodes !== 8'hFF || segments !== 7'h7F) begin
            errors++;
            $display("FAIL async_reset_outputs: anodes=%h segments=%h expected FF 7F",
                     anodes, segments);
        end
        check_counts("async_reset_counts", 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_counts("held_after_reset", 16'h0000, 16'h0000, 16'h0000);
        buttons = 2'b00;
        repeat (10) @(negedge clk);
        press(2'b01, 10, 10);
        check_counts("resume", 16'h0001, 16'h0000, 16'h0000);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 9999; i++) press(2'b01, 3, 3);
        check_counts("to_9999", 16'h9999, 16'h0000, 16'h0000);
        press(2'b01, 3, 6);
        check_counts("wrap", 16'h0000, 16'h0000, 16'h0000);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        buttons = 2'b00;
        sw_mode = 1'b0;
        test_reset();
        test_isolated_a();
        test_mixed();
        test_mode1_scan();
        test_hold_overlap();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_top
`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter REFRESH_BITS, default 10; digit-scan counter width, each digit is lit for 2^REFRESH_BITS clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2; synchronizer depth on each button input (minimum 2).
REQ-003 clk  input  1  system clock, 100 MHz nominal.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 buttons  input  2  raw detector/button inputs, bit0 = channel A, bit1 = channel B, active-high, asynchronous to clk.
REQ-006 sw_mode  input  1  display mode: 0 = show counts A and B, 1 = show coincidence count C.
REQ-007 segments  output  7  active-low segment drive, bit order {g,f,e,d,c,b,a}.
REQ-008 anodes  output  8  active-low digit enables, bit i selects digit i, digit 0 is rightmost.

Function
REQ-009 Each button bit SHALL pass through a SYNC_STAGES flip-flop synchronizer before any use.
REQ-010 A press event SHALL be a synchronized 0->1 transition; one event per press regardless of press length; pulses of 2 cycles or fewer may be missed.
REQ-011 Counter A SHALL increment by 1 on every channel-A press event; counter B likewise for channel B.
REQ-012 Coincidence event SHALL be a 0->1 transition of (syncA AND syncB); counter C SHALL increment by 1 on each.
REQ-013 Simultaneous A and B rising edges in one cycle SHALL increment A, B and C each by exactly 1.
REQ-014 A press that overlaps an already-held other button SHALL count as a coincidence (C+1) as well as a press of its own channel.
REQ-015 Counters A, B, C SHALL each be 4-digit packed BCD (16 bits, 0000-9999); increment carries decimal, 9999 wraps to 0000.
REQ-016 Counter increment latency: count visible on the cycle after the synchronized edge (SYNC_STAGES+1 cycles after raw input rises).
REQ-017 A free-running scan counter of REFRESH_BITS+3 bits SHALL select the active digit from its top 3 bits, cycling digits 0..7.
REQ-018 Exactly one anode bit SHALL be low at any time in mode 0; segments SHALL encode that digit's BCD value.
REQ-019 Mode 0 mapping: digits 3..0 = counter A (thousands..units), digits 7..4 = counter B.
REQ-020 Mode 1 mapping: digits 3..0 = counter C; digits 7..4 blanked (anode high, segments 7'h7F).
REQ-021 Leading zeros SHALL be displayed (e.g. 0005).
REQ-022 Segment codes (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); non-BCD nibble = 7F.
REQ-023 sw_mode SHALL be synchronized (2 FFs); mode change takes effect on the next scan cycle without altering any counter.
REQ-024 Outputs SHALL be registered; segments and anodes change together on the same clk edge.

Reset
REQ-025 rst_n low SHALL asynchronously clear counters A, B, C to 0000, synchronizers and edge-detect registers to 0, scan counter to 0.
REQ-026 During reset anodes SHALL be 8'hFF and segments 7'h7F.
REQ-027 A button held high across reset release SHALL NOT produce a press event.
REQ-028 Reset asserted mid-count SHALL clear all counts immediately; counting resumes from 0000 on the first post-reset edge.

Structure
REQ-029 Shared package holds the BCD-to-segment table, blank code 7'h7F, and digit count constant (8).
REQ-030 One sub-module bcd_counter4 (4-digit BCD counter with inc input, 16-bit digits output, async active-low reset), instantiated three times as counter_A, counter_B, counter_C inside a core_inst hierarchy; scan/decode logic lives in top.

Verification
REQ-031 Reset, 5 isolated A presses of 15 cycles each -> A=0005, B=0000, C=0000.
REQ-032 50 presses: 25 with A and B raised the same cycle, 25 alternating single A/B -> mode 0 shows A and B per press counts, mode 1 shows C=0025.
REQ-033 Hold B, then press A -> A+1, C+1, B unchanged; release and re-press A alone -> C unchanged.
REQ-034 Preload/press A to 9999, one more press -> A=0000, no effect on B or C.
REQ-035 sw_mode=1 for 8*2^REFRESH_BITS cycles -> anodes cycle 1110/1101/1011/0111 on low nibble, upper nibble always 1, segments show C digits.
REQ-036 Assert rst_n low mid-press -> counts 0000, anodes FF immediately (asynchronous); held button after release gives no count.
